fifo_ctrl: RTL and testbench
============================

Name: fifo_ctrl

Overview:
- Pointer and flag controller for the main queue. It is the access side that drives the dual-pointer RAM: it accepts push/pop requests, generates write/read enables and pointers, and tracks occupancy.
- It raises full/empty, almost-full/almost-empty and error flags, and aligns read data with a valid strobe.
- It sits between the upstream producer / downstream consumer and the queue RAM instance.

Parameters:
- DATA_SIZE, 4, data word width in bits.
- MAIN_QUEUE_SIZE, 3, pointer width; queue depth = 2**MAIN_QUEUE_SIZE entries.

Ports:
- clk  input  1  single clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- push  input  1  producer write request.
- pop  input  1  consumer read request.
- data_in  input  DATA_SIZE  push data.
- almost_full_thr  input  MAIN_QUEUE_SIZE+1  almost-full threshold (entries).
- almost_empty_thr  input  MAIN_QUEUE_SIZE+1  almost-empty threshold (entries).
- mem_data_out  input  DATA_SIZE  read data returned by queue RAM.
- mem_write  output  1  RAM write enable.
- mem_read  output  1  RAM read enable.
- mem_wr_ptr  output  MAIN_QUEUE_SIZE  RAM write address.
- mem_rd_ptr  output  MAIN_QUEUE_SIZE  RAM read address.
- mem_data_in  output  DATA_SIZE  RAM write data (equals data_in).
- data_out  output  DATA_SIZE  popped word.
- valid_out  output  1  data_out valid strobe.
- full, empty, almost_full, almost_empty  output  1 each  status flags.
- overflow, underflow  output  1 each  rejected-request error flags.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - wr_ptr = rd_ptr = 0, count = 0, empty = 1, almost_empty = 1.
  - full = almost_full = 0, valid_out = 0, data_out = 0, overflow = underflow = 0.
  - No queue content is considered valid after reset.
- Request acceptance:
  - pop_ok = pop & ~empty.
  - push_ok = push & (~full | pop_ok). When full, a simultaneous push+pop is accepted as a pass-through.
- Memory drive (combinational from current state):
  - mem_write = push_ok, mem_read = pop_ok.
  - mem_wr_ptr = wr_ptr, mem_rd_ptr = rd_ptr, mem_data_in = data_in.
- Pointers:
  - wr_ptr increments on push_ok; rd_ptr increments on pop_ok.
  - Both wrap modulo 2**MAIN_QUEUE_SIZE by natural overflow.
- Count (MAIN_QUEUE_SIZE+1 bits):
  - +1 on push_ok only, -1 on pop_ok only, unchanged on both or neither.
  - Range 0..2**MAIN_QUEUE_SIZE.
- Flags are registered and derived from the next count value, so they are valid the cycle after the request:
  - full = (count == depth), empty = (count == 0).
  - almost_full = (count >= almost_full_thr), almost_empty = (count <= almost_empty_thr).
- Read latency: the RAM registers its output, so data_out = mem_data_out and valid_out = pop_ok delayed 1 cycle. Pop at edge N yields data on cycle N+1.
- Errors:
  - push & ~push_ok sets overflow; pop & empty sets underflow.
  - Default: each is a 1-cycle pulse in the cycle after the rejected request.
- Empty with push+pop in the same cycle: push accepted, pop rejected, underflow asserted.
- Thresholds are sampled every cycle. A threshold change takes effect on the next flag update.

Optional Feature:
- FIFO_ERR_STICKY_EN
  - Defined: overflow/underflow, once set, hold 1 until reset.
  - Undefined: they are single-cycle pulses as above.

Decomposition:
- Shared package/include holds:
  - default DATA_SIZE and MAIN_QUEUE_SIZE constants;
  - the depth constant (2**MAIN_QUEUE_SIZE);
  - the count-width constant (MAIN_QUEUE_SIZE+1).
- These are shared with the RAM and the top-level queue.
- One sub-module, fifo_flags: takes the next count and both thresholds, and registers full/empty/almost_full/almost_empty.
- Pointers, count and error logic stay in fifo_ctrl.

Test Plan:
- Reset, then 8 pushes of 1..8 with thresholds af=6, ae=1:
  - almost_empty drops after push 2; almost_full rises after push 6; full rises after push 8; mem_wr_ptr wraps 7->0.
- From full, 8 pops:
  - data_out = 1..8, each with valid_out one cycle after its pop; empty = 1 after the last pop; no underflow.
- Full plus push with no pop:
  - mem_write = 0, overflow pulses 1 cycle, count stays 8.
  - With FIFO_ERR_STICKY_EN, overflow stays 1 until reset.
- Full plus simultaneous push(9)+pop:
  - both accepted, data_out = oldest word, full stays 1, wr_ptr and rd_ptr both advance.
- Empty plus simultaneous push(A)+pop:
  - push accepted, underflow pulses, count = 1, valid_out stays 0.
- Reset asserted mid-stream with count = 5 and valid_out high:
  - all outputs return to reset values immediately (asynchronously); the next push lands at mem_wr_ptr = 0.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg
// Shared sizing constants for the main queue. The pointer controller, the
// queue RAM and the top-level queue all use these.
//   DATA_SIZE_DEF       default data word width
//   MAIN_QUEUE_SIZE_DEF default pointer width
//   QUEUE_DEPTH         entries for the default pointer width
//   QUEUE_CNT_W         occupancy counter width (pointer width + 1)
package fifo_ctrl_pkg;

    localparam int DATA_SIZE_DEF       = 4;
    localparam int MAIN_QUEUE_SIZE_DEF = 3;
    localparam int QUEUE_DEPTH         = 2 ** MAIN_QUEUE_SIZE_DEF;
    localparam int QUEUE_CNT_W         = MAIN_QUEUE_SIZE_DEF + 1;

    // Depth for an arbitrary pointer width, so overridden instances stay consistent.
    function automatic int depth_of(input int ptr_w);
        return 1 << ptr_w;
    endfunction

endpackage

// File: rtl/fifo_flags.sv
// fifo_flags
// Registers the queue status flags from the next-cycle occupancy count.
// The flags therefore describe the count that is in effect after the edge.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   count_d_i           next occupancy count
//   af_thr_i, ae_thr_i  almost-full / almost-empty thresholds (entries)
//   full_o, empty_o, almost_full_o, almost_empty_o  registered flags
module fifo_flags #(
    parameter int CNT_W = 4,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [CNT_W-1:0] count_d_i,
    input  logic [CNT_W-1:0] af_thr_i,
    input  logic [CNT_W-1:0] ae_thr_i,
    output logic             full_o,
    output logic             empty_o,
    output logic             almost_full_o,
    output logic             almost_empty_o
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic full_q, empty_q, af_q, ae_q;
    logic full_d, empty_d, af_d, ae_d;

    always_comb begin
        full_d  = (count_d_i == DEPTH_C);
        empty_d = (count_d_i == '0);
        af_d    = (count_d_i >= af_thr_i);
        ae_d    = (count_d_i <= ae_thr_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
        end else begin
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
        end
    end

    assign full_o         = full_q;
    assign empty_o        = empty_q;
    assign almost_full_o  = af_q;
    assign almost_empty_o = ae_q;

endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl
// Pointer and flag controller for the main queue. Accepts push/pop requests,
// drives the queue RAM write/read enables and pointers, tracks occupancy and
// reports status and error flags. Read data returns one cycle after a pop.
// Optional macro FIFO_ERR_STICKY_EN: overflow/underflow hold once set until
// reset; without it they are single-cycle pulses.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   push, pop, data_in         producer/consumer requests and push data
//   almost_full_thr/empty_thr  flag thresholds (entries)
//   mem_data_out               registered read data from the queue RAM
//   mem_write, mem_read, mem_wr_ptr, mem_rd_ptr, mem_data_in  RAM drive
//   data_out, valid_out        popped word and its strobe
//   full, empty, almost_full, almost_empty, overflow, underflow  status
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_SIZE       = DATA_SIZE_DEF,
    parameter int MAIN_QUEUE_SIZE = MAIN_QUEUE_SIZE_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_SIZE-1:0]       data_in,
    input  logic [MAIN_QUEUE_SIZE:0]   almost_full_thr,
    input  logic [MAIN_QUEUE_SIZE:0]   almost_empty_thr,
    input  logic [DATA_SIZE-1:0]       mem_data_out,
    output logic                       mem_write,
    output logic                       mem_read,
    output logic [MAIN_QUEUE_SIZE-1:0] mem_wr_ptr,
    output logic [MAIN_QUEUE_SIZE-1:0] mem_rd_ptr,
    output logic [DATA_SIZE-1:0]       mem_data_in,
    output logic [DATA_SIZE-1:0]       data_out,
    output logic                       valid_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int CW    = MAIN_QUEUE_SIZE + 1;
    localparam int DEPTH = depth_of(MAIN_QUEUE_SIZE);

    logic [MAIN_QUEUE_SIZE-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]              count_q, count_d;
    logic                       valid_q, valid_d;
    logic                       ovf_q, ovf_d, unf_q, unf_d;
    logic                       push_ok, pop_ok;
    logic                       full_w, empty_w;

    always_comb begin
        pop_ok   = pop & ~empty_w;
        // When full, a simultaneous pop frees the slot this push takes.
        push_ok  = push & (~full_w | pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        valid_d = pop_ok;
`ifdef FIFO_ERR_STICKY_EN
        ovf_d = ovf_q | (push & ~push_ok);
        unf_d = unf_q | (pop & empty_w);
`else
        ovf_d = push & ~push_ok;
        unf_d = pop & empty_w;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    fifo_flags #(
        .CNT_W (CW),
        .DEPTH (DEPTH)
    ) u_flags (
        .clk_i          (clk),
        .rst_i          (reset),
        .count_d_i      (count_d),
        .af_thr_i       (almost_full_thr),
        .ae_thr_i       (almost_empty_thr),
        .full_o         (full_w),
        .empty_o        (empty_w),
        .almost_full_o  (almost_full),
        .almost_empty_o (almost_empty)
    );

    assign mem_write   = push_ok;
    assign mem_read    = pop_ok;
    assign mem_wr_ptr  = wr_ptr_q;
    assign mem_rd_ptr  = rd_ptr_q;
    assign mem_data_in = data_in;
    assign full        = full_w;
    assign empty       = empty_w;
    assign valid_out   = valid_q;
    // The RAM output register is not reset; gating with the strobe keeps
    // data_out at zero whenever nothing valid is being presented.
    assign data_out    = valid_q ? mem_data_out : '0;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
module tb_fifo_ctrl;

    localparam int DW    = 4;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
`ifdef FIFO_ERR_STICKY_EN
    localparam int STICKY = 1;
`else
    localparam int STICKY = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          push, pop;
    logic [DW-1:0] data_in;
    logic [AW:0]   af_thr, ae_thr;
    logic [DW-1:0] mem_data_out;
    logic          mem_write, mem_read;
    logic [AW-1:0] mem_wr_ptr, mem_rd_ptr;
    logic [DW-1:0] mem_data_in, data_out;
    logic          valid_out, full, empty, almost_full, almost_empty;
    logic          overflow, underflow;

    fifo_ctrl #(.DATA_SIZE(DW), .MAIN_QUEUE_SIZE(AW)) dut (
        .clk              (clk),
        .reset            (reset),
        .push             (push),
        .pop              (pop),
        .data_in          (data_in),
        .almost_full_thr  (af_thr),
        .almost_empty_thr (ae_thr),
        .mem_data_out     (mem_data_out),
        .mem_write        (mem_write),
        .mem_read         (mem_read),
        .mem_wr_ptr       (mem_wr_ptr),
        .mem_rd_ptr       (mem_rd_ptr),
        .mem_data_in      (mem_data_in),
        .data_out         (data_out),
        .valid_out        (valid_out),
        .full             (full),
        .empty            (empty),
        .almost_full      (almost_full),
        .almost_empty     (almost_empty),
        .overflow         (overflow),
        .underflow        (underflow)
    );

    always #5 clk = ~clk;

    // Queue RAM with registered, read-before-write output.
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_write) ram[mem_wr_ptr] <= mem_data_in;
        if (mem_read)  mem_data_out    <= ram[mem_rd_ptr];
    end

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a word queue plus request counters.
    logic [DW-1:0] mq[$];
    int  wp = 0, rp = 0;
    bit  m_full = 0, m_empty = 1, m_af = 0, m_ae = 1, m_valid = 0, m_ovf = 0, m_unf = 0;
    logic [DW-1:0] m_data = '0;
    bit  pok, wok;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            wp = 0; rp = 0;
            m_full = 0; m_empty = 1; m_af = 0; m_ae = 1;
            m_valid = 0; m_data = '0; m_ovf = 0; m_unf = 0;
        end else begin
            pok = pop && (mq.size() != 0);
            wok = push && ((mq.size() < DEPTH) || pok);
            m_ovf = (STICKY != 0 && m_ovf) || (push && !wok);
            m_unf = (STICKY != 0 && m_unf) || (pop && mq.size() == 0);
            m_valid = pok;
            if (pok) begin
                m_data = mq.pop_front();
                rp = (rp + 1) % DEPTH;
            end
            if (wok) begin
                mq.push_back(data_in);
                wp = (wp + 1) % DEPTH;
            end
            m_full  = (mq.size() == DEPTH);
            m_empty = (mq.size() == 0);
            m_af    = (mq.size() >= int'(af_thr));
            m_ae    = (mq.size() <= int'(ae_thr));
        end
    end

    bit c_pok, c_wok;
    always @(negedge clk) begin
        if (started && !reset) begin
            c_pok = pop && (mq.size() != 0);
            c_wok = push && ((mq.size() < DEPTH) || c_pok);
            chk("mem_write", mem_write, c_wok);
            chk("mem_read", mem_read, c_pok);
            chk("mem_wr_ptr", mem_wr_ptr, wp);
            chk("mem_rd_ptr", mem_rd_ptr, rp);
            chk("mem_data_in", mem_data_in, data_in);
            chk("full", full, m_full);
            chk("empty", empty, m_empty);
            chk("almost_full", almost_full, m_af);
            chk("almost_empty", almost_empty, m_ae);
            chk("valid_out", valid_out, m_valid);
            chk("overflow", overflow, m_ovf);
            chk("underflow", underflow, m_unf);
            if (m_valid) chk("data_out", data_out, m_data);
        end
    end

    task automatic drive(input bit p, input bit q, input logic [DW-1:0] d);
        push = p; pop = q; data_in = d;
        @(posedge clk);
        #2;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_ae"}, almost_empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_af"}, almost_full, 0);
        chk({tag, "_valid"}, valid_out, 0);
        chk({tag, "_data"}, data_out, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_unf"}, underflow, 0);
        chk({tag, "_wrptr"}, mem_wr_ptr, 0);
        chk({tag, "_rdptr"}, mem_rd_ptr, 0);
    endtask

    logic [DW-1:0] fillv [7];
    logic [DW-1:0] popv  [3];

    initial begin
        reset = 1'b1; push = 0; pop = 0; data_in = '0;
        af_thr = 4'd6; ae_thr = 4'd1;
        fillv = '{4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1};
        popv  = '{4'hB, 4'hC, 4'hD};
        repeat (2) @(posedge clk);
        #2;
        chk_reset_state("rst0");
        reset = 1'b0;
        started = 1'b1;

        // Fill with 1..8.
        for (int i = 1; i <= 8; i++) begin
            if (i == 8) chk("wrptr_before_wrap", mem_wr_ptr, 7);
            drive(1, 0, DW'(i));
            if (i == 1) chk("ae_after_push1", almost_empty, 1);
            if (i == 2) chk("ae_after_push2", almost_empty, 0);
            if (i == 5) chk("af_after_push5", almost_full, 0);
            if (i == 6) chk("af_after_push6", almost_full, 1);
            if (i == 7) chk("full_after_push7", full, 0);
            if (i == 8) begin
                chk("full_after_push8", full, 1);
                chk("wrptr_wrapped", mem_wr_ptr, 0);
            end
        end

        // Push while full, no pop: rejected.
        push = 1; pop = 0; data_in = 4'hF;
        #1;
        chk("ovf_mem_write", mem_write, 0);
        @(posedge clk);
        #2;
        chk("ovf_set", overflow, 1);
        chk("ovf_full", full, 1);
        drive(0, 0, '0);
        chk("ovf_after", overflow, STICKY);
        chk("ovf_still_full", full, 1);

        // Drain: data 1..8, one cycle after each pop.
        for (int i = 1; i <= 8; i++) begin
            drive(0, 1, '0);
            chk("pop_valid", valid_out, 1);
            chk("pop_data", data_out, i);
        end
        chk("drain_empty", empty, 1);
        chk("drain_no_unf", underflow, 0);

        // Empty with push(A)+pop.
        push = 1; pop = 1; data_in = 4'hA;
        #1;
        chk("ep_mem_write", mem_write, 1);
        chk("ep_mem_read", mem_read, 0);
        @(posedge clk);
        #2;
        chk("ep_unf", underflow, 1);
        chk("ep_valid", valid_out, 0);
        chk("ep_not_empty", empty, 0);
        chk("ep_ae", almost_empty, 1);
        drive(0, 0, '0);
        chk("ep_unf_after", underflow, STICKY);

        // Refill to full.
        for (int i = 0; i < 7; i++) drive(1, 0, fillv[i]);
        chk("refull", full, 1);

        // Full pass-through push(9)+pop.
        drive(1, 1, 4'h9);
        chk("pt_valid", valid_out, 1);
        chk("pt_data", data_out, 4'hA);
        chk("pt_full", full, 1);
        chk("pt_wrptr", mem_wr_ptr, 1);
        chk("pt_rdptr", mem_rd_ptr, 1);

        // Three pops leave count 5 with valid_out high.
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, '0);
            chk("pre_rst_data", data_out, popv[i]);
        end
        push = 0; pop = 0;
        chk("pre_rst_valid", valid_out, 1);
        chk("pre_rst_ae", almost_empty, 0);

        // Asynchronous reset mid-stream.
        reset = 1'b1;
        #1;
        chk_reset_state("rst1");
        @(posedge clk);
        #2;
        reset = 1'b0;
        push = 1; data_in = 4'h5;
        #1;
        chk("post_rst_write", mem_write, 1);
        chk("post_rst_wrptr", mem_wr_ptr, 0);
        @(posedge clk);
        #2;
        chk("post_rst_not_empty", empty, 0);
        drive(0, 0, '0);
        drive(0, 1, '0);
        chk("post_rst_data", data_out, 4'h5);

        drive(0, 0, '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
